cp0_regfile: RTL and testbench

Coprocessor 0 register file: owns Status, Cause, EPC, BadVAddr, Count and Compare, and drives their current values to the memory-access stage, which forwards and evaluates exceptions. It is the write end of that interface. It accepts MTC0 writes from writeback, commits exceptions and ERET, samples hardware interrupt lines, and runs the Count/Compare timer.

---
 rtl/cp0_regfile.sv | 141 ++++++++++++++
 tb/tb_cp0_regfile.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// Coprocessor 0 register file: Status, Cause, EPC, BadVAddr, Count and Compare,
// with exception/ERET commit, MTC0 writes, interrupt sampling and the Count/Compare timer.
module cp0_regfile #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cp0,
    input  logic [4:0]            wb_cp0_write_addr,
    input  logic [DATA_WIDTH-1:0] wb_cp0_write,
    input  logic [4:0]            raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic                  exception_valid,
    input  logic [4:0]            exc_code,
    input  logic [DATA_WIDTH-1:0] exc_pc,
    input  logic                  exc_in_delay_slot,
    input  logic [DATA_WIDTH-1:0] exc_badvaddr,
    input  logic                  eret,
    input  logic [5:0]            hw_int,
    output logic [DATA_WIDTH-1:0] cp0_status,
    output logic [DATA_WIDTH-1:0] cp0_cause,
    output logic [DATA_WIDTH-1:0] cp0_epc,
    output logic                  timer_int
);

    logic        r_bev;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic        r_ti;
    logic [5:0]  r_hw;
    logic [1:0]  r_sw;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_toggle;

    logic w_wr;
    logic w_wr_count;
    logic w_wr_compare;
    logic w_wr_status;
    logic w_wr_cause;
    logic w_wr_epc;
    logic w_timer_hit;
    logic w_exc_addr;

    // A committing exception flushes the writeback instruction, so its MTC0 never lands.
    assign w_wr         = wb_cp0 & ~exception_valid;
    assign w_wr_count   = w_wr && (wb_cp0_write_addr == 5'd9);
    assign w_wr_compare = w_wr && (wb_cp0_write_addr == 5'd11);
    assign w_wr_status  = w_wr && (wb_cp0_write_addr == 5'd12) && !eret;
    assign w_wr_cause   = w_wr && (wb_cp0_write_addr == 5'd13);
    assign w_wr_epc     = w_wr && (wb_cp0_write_addr == 5'd14);
    assign w_timer_hit  = (r_count == r_compare) && (r_compare != '0) && !w_wr_compare;
    assign w_exc_addr   = (exc_code == 5'd4) || (exc_code == 5'd5);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bev      <= 1'b1;
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ti       <= 1'b0;
            r_hw       <= '0;
            r_sw       <= '0;
            r_exccode  <= '0;
            r_epc      <= '0;
            r_badvaddr <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_toggle   <= 1'b0;
        end else begin
            r_hw <= hw_int;

            if (w_wr_count) begin
                r_count  <= wb_cp0_write;
                r_toggle <= 1'b0;
            end else begin
                r_toggle <= ~r_toggle;
                if (r_toggle)
                    r_count <= r_count + 32'd1;
            end

            if (w_wr_compare) begin
                r_compare <= wb_cp0_write;
                r_ti      <= 1'b0;
            end else if (w_timer_hit) begin
                r_ti <= 1'b1;
            end

            if (exception_valid) begin
                // Nested exceptions keep the original return point and BD.
                if (!r_exl) begin
                    r_epc <= exc_in_delay_slot ? exc_pc - 32'd4 : exc_pc;
                    r_bd  <= exc_in_delay_slot;
                end
                r_exl     <= 1'b1;
                r_exccode <= exc_code;
                if (w_exc_addr)
                    r_badvaddr <= exc_badvaddr;
            end else begin
                if (eret)
                    r_exl <= 1'b0;
                if (w_wr_status) begin
                    r_bev <= wb_cp0_write[22];
                    r_im  <= wb_cp0_write[15:8];
                    r_exl <= wb_cp0_write[1];
                    r_ie  <= wb_cp0_write[0];
                end
                if (w_wr_cause)
                    r_sw <= wb_cp0_write[9:8];
                if (w_wr_epc)
                    r_epc <= wb_cp0_write;
            end
        end
    end

    assign cp0_status = {9'b0, r_bev, 6'b0, r_im, 6'b0, r_exl, r_ie};
    assign cp0_cause  = {r_bd, r_ti, 14'b0, r_hw[5] | r_ti, r_hw[4:0], r_sw, 1'b0, r_exccode, 2'b00};
    assign cp0_epc    = r_epc;
    assign timer_int  = r_ti;

    always_comb begin
        rdata = '0;
        case (raddr)
            5'd8:    rdata = r_badvaddr;
            5'd9:    rdata = r_count;
            5'd11:   rdata = r_compare;
            5'd12:   rdata = cp0_status;
            5'd13:   rdata = cp0_cause;
            5'd14:   rdata = r_epc;
            5'd15:   rdata = 32'h0000_0001;
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_cp0_regfile;

    logic        clk;
    logic        rst_n;
    logic        wb_cp0;
    logic [4:0]  wb_cp0_write_addr;
    logic [31:0] wb_cp0_write;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic        exception_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        timer_int;

    int total = 0;
    int bad   = 0;

    cp0_regfile #(.DATA_WIDTH(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .wb_cp0            (wb_cp0),
        .wb_cp0_write_addr (wb_cp0_write_addr),
        .wb_cp0_write      (wb_cp0_write),
        .raddr             (raddr),
        .rdata             (rdata),
        .exception_valid   (exception_valid),
        .exc_code          (exc_code),
        .exc_pc            (exc_pc),
        .exc_in_delay_slot (exc_in_delay_slot),
        .exc_badvaddr      (exc_badvaddr),
        .eret              (eret),
        .hw_int            (hw_int),
        .cp0_status        (cp0_status),
        .cp0_cause         (cp0_cause),
        .cp0_epc           (cp0_epc),
        .timer_int         (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: Count is a load value plus half the edges since that load.
    logic [31:0] m_status, m_epc, m_bad, m_compare, m_cbase, m_ticks;
    logic        m_bd, m_ti, m_valid;
    logic [5:0]  m_hw;
    logic [1:0]  m_sw;
    logic [4:0]  m_exc;
    logic [31:0] cnow;
    logic        wr;

    initial m_valid = 1'b0;

    function automatic logic [31:0] m_count();
        return m_cbase + (m_ticks >> 1);
    endfunction

    function automatic logic [31:0] m_cause();
        logic [31:0] c;
        c = 32'(m_bd) * 32'h8000_0000 + 32'(m_ti) * 32'h4000_0000
          + 32'(m_hw[5] | m_ti) * 32'h8000 + 32'(m_hw[4:0]) * 32'h400
          + 32'(m_sw) * 32'h100 + 32'(m_exc) * 32'h4;
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count();
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return 32'd1;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_status = 32'h0040_0000; m_epc = 0; m_bad = 0; m_compare = 0;
            m_cbase = 0; m_ticks = 0; m_bd = 0; m_ti = 0; m_hw = 0; m_sw = 0; m_exc = 0;
            m_valid = 1'b1;
        end else begin
            cnow = m_count();
            wr   = wb_cp0 && !exception_valid;
            if (wr && wb_cp0_write_addr == 11) begin
                m_compare = wb_cp0_write;
                m_ti = 0;
            end else if (cnow == m_compare && m_compare != 0) begin
                m_ti = 1;
            end
            if (wr && wb_cp0_write_addr == 9) begin
                m_cbase = wb_cp0_write;
                m_ticks = 0;
            end else begin
                m_ticks = m_ticks + 1;
            end
            m_hw = hw_int;
            if (exception_valid) begin
                if ((m_status & 32'h2) == 0) begin
                    m_epc = exc_in_delay_slot ? exc_pc - 4 : exc_pc;
                    m_bd  = exc_in_delay_slot;
                end
                m_status = m_status | 32'h2;
                m_exc = exc_code;
                if (exc_code == 4 || exc_code == 5) m_bad = exc_badvaddr;
            end else begin
                if (eret) m_status = m_status & ~32'h2;
                else if (wr && wb_cp0_write_addr == 12) m_status = wb_cp0_write & 32'h0040_FF03;
                if (wr && wb_cp0_write_addr == 13) m_sw = wb_cp0_write[9:8];
                if (wr && wb_cp0_write_addr == 14) m_epc = wb_cp0_write;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("status", cp0_status, m_status);
            chk("cause", cp0_cause, m_cause());
            chk("epc", cp0_epc, m_epc);
            chk("timer_int", {31'b0, timer_int}, {31'b0, m_ti});
            chk("rdata", rdata, m_read(raddr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        wb_cp0 = 1'b1; wb_cp0_write_addr = a; wb_cp0_write = d;
        cyc();
        wb_cp0 = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds, input logic [31:0] bv);
        exception_valid = 1'b1; exc_code = code; exc_pc = pc; exc_in_delay_slot = ds; exc_badvaddr = bv;
        cyc();
        exception_valid = 1'b0;
    endtask

    logic [4:0] addr_tab [8];

    initial begin
        addr_tab = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15};
        rst_n = 0; wb_cp0 = 0; wb_cp0_write_addr = 0; wb_cp0_write = 0; raddr = 0;
        exception_valid = 0; exc_code = 0; exc_pc = 0; exc_in_delay_slot = 0;
        exc_badvaddr = 0; eret = 0; hw_int = 0;
        cyc(); cyc();
        rst_n = 1;

        repeat (10) cyc();
        raddr = 9; #1;
        chk("lit_count5", rdata, 32'd5);
        chk("lit_status_rst", cp0_status, 32'h0040_0000);
        chk("lit_cause_rst", cp0_cause, 32'h0);
        raddr = 15; #1;
        chk("lit_prid", rdata, 32'd1);

        mtc0(11, 32'd3);
        mtc0(9, 32'd0);
        repeat (6) cyc();
        raddr = 9; #1;
        chk("lit_count3", rdata, 32'd3);
        chk("lit_ti_before", {31'b0, timer_int}, 32'd0);
        cyc();
        chk("lit_ti_set", {31'b0, timer_int}, 32'd1);
        chk("lit_cause_ti", cp0_cause & 32'hC000_8000, 32'h4000_8000);
        mtc0(11, 32'd100);
        chk("lit_ti_clr", {31'b0, timer_int}, 32'd0);
        chk("lit_cause_ti_clr", cp0_cause & 32'hC000_8000, 32'h0);

        exc(4, 32'h0000_1008, 1'b1, 32'h0000_2003);
        raddr = 8; #1;
        chk("lit_epc_ds", cp0_epc, 32'h0000_1004);
        chk("lit_cause_exc4", cp0_cause & 32'h8000_007C, 32'h8000_0010);
        chk("lit_exl", cp0_status, 32'h0040_0002);
        chk("lit_badvaddr", rdata, 32'h0000_2003);
        exc(8, 32'h0000_2000, 1'b0, 32'h0000_5555);
        chk("lit_epc_nested", cp0_epc, 32'h0000_1004);
        chk("lit_exc8", cp0_cause & 32'h0000_007C, 32'h0000_0020);
        chk("lit_bad_kept", rdata, 32'h0000_2003);

        wb_cp0 = 1; wb_cp0_write_addr = 12; wb_cp0_write = 0;
        exc(0, 32'h0000_3000, 1'b0, 32'h0);
        wb_cp0 = 0;
        chk("lit_exc_beats_mtc0", cp0_status, 32'h0040_0002);
        wb_cp0 = 1; wb_cp0_write_addr = 14; wb_cp0_write = 32'h40; eret = 1;
        cyc();
        wb_cp0 = 0; eret = 0;
        chk("lit_eret_exl", cp0_status, 32'h0040_0000);
        chk("lit_eret_epc", cp0_epc, 32'h0000_0040);

        rst_n = 0; cyc(); rst_n = 1;
        hw_int = 6'b100001;
        mtc0(13, 32'hFFFF_FFFF);
        chk("lit_cause_hw_sw", cp0_cause, 32'h0000_8700);
        mtc0(9, 32'hFFFF_FFFF);
        raddr = 9; #1;
        chk("lit_count_max", rdata, 32'hFFFF_FFFF);
        cyc(); cyc();
        chk("lit_count_wrap", rdata, 32'h0);
        mtc0(12, 32'hFFFF_FFFF);
        chk("lit_status_mask", cp0_status, 32'h0040_FF03);
        rst_n = 0; cyc(); rst_n = 1;
        chk("lit_rst_status", cp0_status, 32'h0040_0000);
        chk("lit_rst_cause", cp0_cause, 32'h0);
        chk("lit_rst_epc", cp0_epc, 32'h0);
        chk("lit_rst_count", rdata, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            wb_cp0 = ($urandom_range(0, 2) == 0);
            wb_cp0_write_addr = addr_tab[$urandom_range(0, 7)];
            wb_cp0_write = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            exception_valid = ($urandom_range(0, 15) == 0);
            exc_code = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(4, 5)) : 5'($urandom_range(0, 31));
            exc_pc = $urandom & 32'hFFFF_FFFC;
            exc_in_delay_slot = 1'($urandom_range(0, 1));
            exc_badvaddr = $urandom;
            eret = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom_range(0, 63));
            raddr = 5'($urandom_range(0, 31));
            cyc();
        end
        rst_n = 1; wb_cp0 = 0; exception_valid = 0; eret = 0;
        cyc();
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
